// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit arbiter and the receive/transmit paths:
// arbiter state encoding, default byte width and the baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } tx_arb_state_e;

  localparam int DefaultWidth = 8;

  localparam int ClkHz    = 100_000_000;
  localparam int BaudRate = 115_200;
  localparam int BaudDiv  = ClkHz / BaudRate;

  // Index/counter width that stays legal when the range collapses to a single value.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, modulo NumReq.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = clog2_min1(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] cidx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cidx  = '0;
    for (int k = 0; k < NumReq; k++) begin
      cidx = (int'(ptr_i) + k >= NumReq) ? IdxW'(int'(ptr_i) + k - NumReq)
                                         : IdxW'(int'(ptr_i) + k);
      if (!any_o && req_i[cidx]) begin
        any_o       = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NumReq byte producers; a grant is held for a
// whole burst (last, burst cap or idle timeout) so frames never interleave.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int Width       = DefaultWidth,
  parameter int MaxBurst    = 16,
  parameter int HoldTimeout = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq-1:0]       req_last_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic                    tx_start_o,
  output logic [Width-1:0]        tx_data_o,
  input  logic                    tx_done_i,
  output logic [NumReq-1:0]       grant_o,
  output logic                    busy_o
);

  localparam int IdxW   = clog2_min1(NumReq);
  localparam int BurstW = clog2_min1(MaxBurst);
  localparam int IdleW  = clog2_min1(HoldTimeout);

  localparam logic [BurstW-1:0] BurstLast = BurstW'(MaxBurst - 1);
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(HoldTimeout - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NumReq - 1);

  tx_arb_state_e     state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   gid_q;
  logic [BurstW-1:0] burst_cnt_q;
  logic [IdleW-1:0]  idle_cnt_q;
  logic              last_q;

  logic [NumReq-1:0] win_gnt;
  logic [IdxW-1:0]   win_idx;
  logic              win_any;
  logic [IdxW-1:0]   sel_idx;
  logic [Width-1:0]  sel_data;
  logic              sel_last;
  logic [IdxW-1:0]   ptr_release;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // In HOLD only the owner may load; in IDLE the round-robin winner does.
  assign sel_idx     = (state_q == ST_HOLD) ? gid_q : win_idx;
  assign sel_data    = req_data_i[int'(sel_idx) * Width +: Width];
  assign sel_last    = req_last_i[sel_idx];
  assign ptr_release = (gid_q == IdxLast) ? '0 : gid_q + 1'b1;

  always_comb begin
    req_ready_o = '0;
    if (rst_ni) begin
      case (state_q)
        ST_IDLE: req_ready_o = win_gnt;
        ST_HOLD: req_ready_o[gid_q] = req_valid_i[gid_q];
        default: req_ready_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      last_q      <= 1'b0;
      tx_start_o  <= 1'b0;
      tx_data_o   <= '0;
      grant_o     <= '0;
      busy_o      <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            tx_data_o   <= sel_data;
            last_q      <= sel_last;
            gid_q       <= win_idx;
            burst_cnt_q <= '0;
            grant_o     <= win_gnt;
            busy_o      <= 1'b1;
            tx_start_o  <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done_i) begin
            if (last_q || burst_cnt_q == BurstLast) begin
              ptr_q   <= ptr_release;
              grant_o <= '0;
              busy_o  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
              idle_cnt_q  <= '0;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (req_valid_i[gid_q]) begin
            tx_data_o  <= sel_data;
            last_q     <= sel_last;
            tx_start_o <= 1'b1;
            state_q    <= ST_START;
          end else if (idle_cnt_q == IdleLast) begin
            ptr_q   <= ptr_release;
            grant_o <= '0;
            busy_o  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed timing steps, fixed frame scenarios and
// randomized frame sets compared against a transaction-level scheduling model.
module tb_uart_tx_arbiter;

  localparam int NumReq      = 4;
  localparam int Width       = 8;
  localparam int MaxBurst    = 16;
  localparam int HoldTimeout = 8;

  logic                    clk = 1'b0;
  logic                    rst_ni;
  logic [NumReq-1:0]       req_valid_i;
  logic [NumReq-1:0]       req_last_i;
  logic [NumReq*Width-1:0] req_data_i;
  logic [NumReq-1:0]       req_ready_o;
  logic                    tx_start_o;
  logic [Width-1:0]        tx_data_o;
  logic                    tx_done_i;
  logic [NumReq-1:0]       grant_o;
  logic                    busy_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NumReq      (NumReq),
    .Width       (Width),
    .MaxBurst    (MaxBurst),
    .HoldTimeout (HoldTimeout)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .tx_done_i   (tx_done_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  // Per-requester byte queues {last, data}; expected transmissions {index, data}.
  logic [8:0]  rq [NumReq][$];
  logic [11:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [7:0] d);
    req_valid_i[i]              = v;
    req_last_i[i]               = l;
    req_data_i[i*Width +: Width] = d;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    tx_done_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic push(input int i, input logic l, input logic [7:0] d);
    rq[i].push_back({l, d});
  endtask

  task automatic expect_tx(input int i, input logic [7:0] d);
    exp_q.push_back({4'(i), d});
  endtask

  function automatic int idx_of(input logic [NumReq-1:0] g);
    idx_of = -1;
    for (int i = 0; i < NumReq; i++) if (g[i]) idx_of = i;
  endfunction

  // Scheduling model: grant the first non-empty queue from ptr, then drain it until
  // a last byte, MaxBurst bytes, or the queue runs dry (the idle timeout).
  task automatic model_build();
    logic [8:0] mq [NumReq][$];
    int ptr;
    int w;
    int n;
    bit found;
    logic [8:0] b;
    ptr = 0;
    w   = 0;
    exp_q.delete();
    for (int i = 0; i < NumReq; i++) mq[i] = rq[i];
    forever begin
      found = 1'b0;
      for (int k = 0; k < NumReq && !found; k++) begin
        w     = (ptr + k) % NumReq;
        found = (mq[w].size() > 0);
      end
      if (!found) break;
      n = 0;
      do begin
        b = mq[w].pop_front();
        exp_q.push_back({4'(w), b[7:0]});
        n++;
      end while (!b[8] && n < MaxBurst && mq[w].size() > 0);
      ptr = (w + 1) % NumReq;
    end
  endtask

  // Producers present their queue heads continuously; a transmitter answers each
  // start with a done pulse after a random delay.
  task automatic run(input string tag, input int budget, input int dly_max);
    int cyc;
    int cd;
    int gi;
    bit active;
    logic prev_start;
    logic [NumReq-1:0] hs;
    logic [11:0] e;
    cyc        = 0;
    cd         = -1;
    active     = 1'b1;
    prev_start = 1'b0;
    while (active && cyc < budget) begin
      if (tx_start_o) begin
        chk({tag, "_start_pulse"}, prev_start, 1'b0);
        chk({tag, "_start_expected"}, exp_q.size() > 0, 1'b1);
        gi = idx_of(grant_o);
        e  = 12'hfff;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_byte"}, {gi[3:0], tx_data_o}, e);
        cd = $urandom_range(dly_max, 1);
      end
      prev_start = tx_start_o;
      for (int i = 0; i < NumReq; i++) begin
        if (rq[i].size() > 0) drive(i, 1'b1, rq[i][0][8], rq[i][0][7:0]);
        else                  drive(i, 1'b0, 1'b0, 8'h00);
      end
      tx_done_i = (cd == 0);
      #1;
      chk({tag, "_ready_onehot"}, $onehot0(req_ready_o), 1'b1);
      chk({tag, "_ready_valid"}, req_ready_o & ~req_valid_i, '0);
      chk({tag, "_busy_grant"}, busy_o, |grant_o);
      hs = req_ready_o & req_valid_i;
      tick();
      for (int i = 0; i < NumReq; i++) if (hs[i]) void'(rq[i].pop_front());
      if (cd >= 0) cd--;
      cyc++;
      active = busy_o || (cd >= 0);
      for (int i = 0; i < NumReq; i++) if (rq[i].size() > 0) active = 1'b1;
    end
    chk({tag, "_within_budget"}, cyc < budget, 1'b1);
    chk({tag, "_all_sent"}, exp_q.size(), 0);
    req_valid_i = '0;
    tx_done_i   = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '1;
    req_last_i  = '0;
    req_data_i  = '0;
    tx_done_i   = 1'b0;
    #2;
    chk("rst_ready", req_ready_o, '0);
    chk("rst_start", tx_start_o, 1'b0);
    chk("rst_data", tx_data_o, '0);
    chk("rst_grant", grant_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    do_reset();

    // Single byte: accept, start one cycle later, release one cycle after done.
    drive(0, 1'b1, 1'b1, 8'h41);
    #1;
    chk("single_ready", req_ready_o, 4'b0001);
    tick();
    chk("single_start", tx_start_o, 1'b1);
    chk("single_data", tx_data_o, 8'h41);
    chk("single_grant", grant_o, 4'b0001);
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(3, 1'b1, 1'b1, 8'h99);
    tx_done_i = 1'b1;
    #1;
    chk("single_other_ignored", req_ready_o, '0);
    tick();
    tx_done_i = 1'b0;
    drive(3, 1'b0, 1'b0, 8'h00);
    chk("single_pulse", tx_start_o, 1'b0);
    chk("single_done_ignored_in_start", busy_o, 1'b1);
    repeat (17) tick();
    chk("single_wait_busy", busy_o, 1'b1);
    chk("single_data_stable", tx_data_o, 8'h41);
    tx_done_i = 1'b1;
    tick();
    tx_done_i = 1'b0;
    chk("single_release_busy", busy_o, 1'b0);
    chk("single_release_grant", grant_o, '0);

    // Hold timeout: req1 sends one byte without last, then goes quiet.
    drive(1, 1'b1, 1'b0, 8'h55);
    #1;
    chk("hold_ready", req_ready_o, 4'b0010);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00);
    chk("hold_data", tx_data_o, 8'h55);
    tick();
    tx_done_i = 1'b1;
    tick();
    tx_done_i = 1'b0;
    drive(0, 1'b1, 1'b1, 8'h66);
    #1;
    chk("hold_other_ignored", req_ready_o, '0);
    repeat (7) tick();
    chk("hold_still_busy", busy_o, 1'b1);
    chk("hold_grant", grant_o, 4'b0010);
    drive(0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("hold_timeout_release", busy_o, 1'b0);
    drive(1, 1'b1, 1'b1, 8'h71);
    drive(2, 1'b1, 1'b1, 8'h72);
    #1;
    chk("hold_ptr_is_2", req_ready_o, 4'b0100);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00);
    drive(2, 1'b0, 1'b0, 8'h00);
    chk("mid_grant", grant_o, 4'b0100);
    tick();

    // Reset while in WAIT: outputs clear at once, service restarts from ptr 0.
    req_valid_i = '1;
    rst_ni      = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_grant", grant_o, '0);
    chk("mid_rst_data", tx_data_o, '0);
    chk("mid_rst_start", tx_start_o, 1'b0);
    chk("mid_rst_ready", req_ready_o, '0);
    req_valid_i = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    drive(1, 1'b1, 1'b1, 8'h81);
    drive(3, 1'b1, 1'b1, 8'h83);
    #1;
    chk("post_rst_ptr0", req_ready_o, 4'b0010);
    tick();
    chk("post_rst_data", tx_data_o, 8'h81);

    // Round robin with every requester valid: 0,1,2,3 then wrap to 0.
    do_reset();
    push(0, 1'b1, 8'hA0); push(0, 1'b1, 8'hA4);
    push(1, 1'b1, 8'hA1); push(2, 1'b1, 8'hA2); push(3, 1'b1, 8'hA3);
    expect_tx(0, 8'hA0); expect_tx(1, 8'hA1); expect_tx(2, 8'hA2);
    expect_tx(3, 8'hA3); expect_tx(0, 8'hA4);
    run("rr", 400, 4);

    // Burst lock: req1 stays valid but waits for req2's three-byte frame.
    push(1, 1'b1, 8'h30); push(1, 1'b1, 8'h20);
    push(2, 1'b0, 8'h10); push(2, 1'b0, 8'h11); push(2, 1'b1, 8'h12);
    expect_tx(1, 8'h30); expect_tx(2, 8'h10); expect_tx(2, 8'h11);
    expect_tx(2, 8'h12); expect_tx(1, 8'h20);
    run("burst_lock", 400, 4);

    // Burst cap: 20 bytes without last are cut after 16, req3 goes next.
    do_reset();
    for (int j = 0; j < 20; j++) push(0, 1'b0, 8'(j));
    push(3, 1'b1, 8'hC3);
    for (int j = 0; j < 16; j++) expect_tx(0, 8'(j));
    expect_tx(3, 8'hC3);
    for (int j = 16; j < 20; j++) expect_tx(0, 8'(j));
    run("burst_cap", 1000, 3);

    // Randomized frame sets against the scheduling model.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < NumReq; i++) begin
        rq[i].delete();
        for (int j = 0; j < int'($urandom_range(20, 0)); j++)
          push(i, ($urandom_range(2 + r * 6, 0) == 0), 8'($urandom));
      end
      model_build();
      run("rand", 6000, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
